// File: rtl/interrupt_sequencer_pkg.sv
// Shared CPU-side definitions for interrupt entry sequencing.
// Holds the sequencer state encoding, the default interrupt vector and
// the default drain depth so fetch and control agree on both.
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PUSH_HI = 3'd2,
    ST_PUSH_LO = 3'd3,
    ST_LOAD_PC = 3'd4,
    ST_ACTIVE  = 3'd5
  } seq_state_t;

  localparam logic [31:0] VECTOR_ADDR_DEFAULT  = 32'h0000_0002;
  localparam int          DRAIN_CYCLES_DEFAULT = 3;
  // Wide enough for DRAIN_CYCLES-1 with DRAIN_CYCLES in 1..7.
  localparam int          CNT_W                = 3;

  // Fetch is held for the whole entry sequence, from drain to vector load.
  function automatic logic is_frozen(input seq_state_t s);
    return (s == ST_DRAIN) || (s == ST_PUSH_HI) ||
           (s == ST_PUSH_LO) || (s == ST_LOAD_PC);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pipeline-side signal bundle of the interrupt sequencer.
// Ports: request/stall/PC/branch/push-ready/RTI inputs to the sequencer,
// freeze/push/PC-load/status outputs from it.
interface interrupt_sequencer_if;

  logic        i_interrupt;
  logic        i_stall;
  logic [31:0] i_pc;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_push_ready;
  logic        i_rti;

  logic        o_freeze_fetch;
  logic        o_push_valid;
  logic [15:0] o_push_data;
  logic        o_pc_load;
  logic [31:0] o_pc_value;
  logic        o_in_service;
  logic        o_busy;

  // Sequencer side: drives the pipeline control strobes.
  modport master (
    input  i_interrupt, i_stall, i_pc, i_branch_taken, i_branch_target,
           i_push_ready, i_rti,
    output o_freeze_fetch, o_push_valid, o_push_data, o_pc_load,
           o_pc_value, o_in_service, o_busy
  );

  // Pipeline side: supplies status and consumes the control strobes.
  modport slave (
    output i_interrupt, i_stall, i_pc, i_branch_taken, i_branch_target,
           i_push_ready, i_rti,
    input  o_freeze_fetch, o_push_valid, o_push_data, o_pc_load,
           o_pc_value, o_in_service, o_busy
  );

endinterface

// File: rtl/interrupt_sequencer.sv
// Purpose: latch an interrupt edge, freeze fetch, drain, push the 32-bit
//   resume PC as two 16-bit stack words, load the vector, mask until RTI.
// Latency: edge at N -> DRAIN N+2 .. N+1+DRAIN_CYCLES, then PUSH_HI,
//   PUSH_LO, LOAD_PC on consecutive cycles, ACTIVE after.
// Backpressure: each push word is held stable until i_push_ready; fetch
//   stays frozen for the whole wait.
// Ports: i_clk, i_reset (async active-low), bus (interrupt_sequencer_if.master).
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter logic [31:0] VECTOR_ADDR  = VECTOR_ADDR_DEFAULT
) (
  input logic                   i_clk,
  input logic                   i_reset,
  interrupt_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic             r_int_d;
  logic             r_pending;
  logic [31:0]      r_saved_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;
  logic             w_enter;

  assign w_edge  = bus.i_interrupt & ~r_int_d;
  assign w_enter = (r_state == ST_IDLE) && r_pending && !bus.i_stall;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_enter) w_next_state = ST_DRAIN;
      ST_DRAIN:   if (r_cnt == '0) w_next_state = ST_PUSH_HI;
      ST_PUSH_HI: if (bus.i_push_ready) w_next_state = ST_PUSH_LO;
      ST_PUSH_LO: if (bus.i_push_ready) w_next_state = ST_LOAD_PC;
      ST_LOAD_PC: w_next_state = ST_ACTIVE;
      ST_ACTIVE:  if (bus.i_rti) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Edge detector, pending flag, resume PC and drain counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_int_d    <= 1'b0;
      r_pending  <= 1'b0;
      r_saved_pc <= '0;
      r_cnt      <= '0;
    end else begin
      r_int_d <= bus.i_interrupt;

      // A fresh edge always wins over the clear at vector load, so a
      // request arriving in that exact cycle is not lost.
      if (w_edge) begin
        r_pending <= 1'b1;
      end else if (r_state == ST_LOAD_PC) begin
        r_pending <= 1'b0;
      end

      if (w_enter) begin
        r_saved_pc <= bus.i_pc;
        r_cnt      <= DRAIN_LOAD;
      end else if (r_state == ST_DRAIN) begin
        // In-flight branches resolving during drain redirect the resume
        // point; the last one to resolve is the real next instruction.
        if (bus.i_branch_taken) begin
          r_saved_pc <= bus.i_branch_target;
        end
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    bus.o_freeze_fetch = is_frozen(r_state);
    bus.o_push_valid   = 1'b0;
    bus.o_push_data    = '0;
    bus.o_pc_load      = 1'b0;
    bus.o_pc_value     = '0;
    bus.o_in_service   = 1'b0;
    bus.o_busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_PUSH_HI: begin
        bus.o_push_valid = 1'b1;
        bus.o_push_data  = r_saved_pc[31:16];
      end
      ST_PUSH_LO: begin
        bus.o_push_valid = 1'b1;
        bus.o_push_data  = r_saved_pc[15:0];
      end
      ST_LOAD_PC: begin
        bus.o_pc_load  = 1'b1;
        bus.o_pc_value = VECTOR_ADDR;
      end
      ST_ACTIVE: begin
        bus.o_in_service = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
